// File: rtl/urv_imem_arbiter.sv
// rtl/urv_imem_arbiter.sv - core/host arbiter for a single-port instruction RAM (burst mode: URV_IMEM_ARB_BURST_EN)
module urv_imem_arbiter #(
    parameter int HOST_BURST_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        h_req_i,
    input  logic        h_we_i,
    input  logic [31:0] h_addr_i,
    input  logic [31:0] h_wdata_i,
    output logic        h_gnt_o,
    output logic        h_ack_o,
    output logic [31:0] h_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

`ifdef URV_IMEM_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    // Out-of-range settings are clamped so the 4-bit counter can always reach the limit.
    localparam int CFG_MAX = (HOST_BURST_MAX < 1) ? 1 :
                             (HOST_BURST_MAX > 15) ? 15 : HOST_BURST_MAX;
    // Without burst support every host grant is followed by a forced core slot.
    localparam logic [3:0] LIMIT = BURST_EN ? 4'(CFG_MAX) : 4'd1;

    typedef enum logic {
        ST_CORE,
        ST_HOST
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_base;
    logic [3:0] cnt_inc;
    logic       force_q, force_d;
    logic       ack_q;
    logic       valid_q;
    logic       grant;

    // Host wins unless the previous cycle closed a full burst; nothing is granted in reset.
    assign grant   = rst_n_i && h_req_i && !force_q;
    assign h_gnt_o = grant;

    // RAM port follows the host on grant cycles, otherwise the core fetch address.
    assign mem_addr_o  = grant ? h_addr_i : im_addr_i;
    assign mem_we_o    = grant && h_we_i;
    assign mem_wdata_o = h_wdata_i;

    // Read data is steered to whichever side owned the RAM on the previous cycle.
    assign im_valid_o = valid_q;
    assign im_data_o  = valid_q ? mem_rdata_i : 32'd0;
    assign h_ack_o    = ack_q;
    assign h_rdata_o  = ack_q ? mem_rdata_i : 32'd0;

    // Next-state: count grants within a burst and force one core slot at the limit.
    always_comb begin
        state_d  = ST_CORE;
        cnt_d    = 4'd0;
        force_d  = 1'b0;
        cnt_base = (state_q == ST_HOST) ? cnt_q : 4'd0;
        cnt_inc  = (cnt_base >= LIMIT) ? LIMIT : cnt_base + 4'd1;
        if (grant) begin
            cnt_d   = cnt_inc;
            force_d = (cnt_inc == LIMIT);
            state_d = force_d ? ST_CORE : ST_HOST;
        end
    end

    // State register plus the one-cycle ownership flags that qualify read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CORE;
            cnt_q   <= 4'd0;
            force_q <= 1'b0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
            ack_q   <= grant;
            valid_q <= !grant;
        end
    end

endmodule

// File: tb/tb_urv_imem_arbiter.sv
// tb/tb_urv_imem_arbiter.sv - directed self-checking bench for urv_imem_arbiter
module tb_urv_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_valid;
    logic        h_req;
    logic        h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_gnt;
    logic        h_ack;
    logic [31:0] h_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] gv, av, vv;

`ifdef URV_IMEM_ARB_BURST_EN
    localparam int          HOLD_N    = 10;
    localparam logic [31:0] EXP_GNT   = 32'h3DE;  // 1111011110
    localparam logic [31:0] EXP_ACK   = 32'h1EF;  // 0111101111
    localparam logic [31:0] EXP_VALID = 32'h210;  // 1000010000
`else
    localparam int          HOLD_N    = 6;
    localparam logic [31:0] EXP_GNT   = 32'h2A;   // 101010
    localparam logic [31:0] EXP_ACK   = 32'h15;   // 010101
    localparam logic [31:0] EXP_VALID = 32'h2A;   // 101010
`endif

    urv_imem_arbiter #(.HOST_BURST_MAX(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .im_addr_i  (im_addr),
        .im_data_o  (im_data),
        .im_valid_o (im_valid),
        .h_req_i    (h_req),
        .h_we_i     (h_we),
        .h_addr_i   (h_addr),
        .h_wdata_i  (h_wdata),
        .h_gnt_o    (h_gnt),
        .h_ack_o    (h_ack),
        .h_rdata_o  (h_rdata),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one-cycle read latency; word at byte address a preloaded to 0xA0000000+a.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + 32'(i * 4);
    end

    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[9:2]];
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        im_addr = 32'd0;
        h_req   = 1'b1;
        h_we    = 1'b1;
        h_addr  = 32'h0;
        h_wdata = 32'h0;
        #2;
        chk("rst_valid", {31'd0, im_valid}, 32'd0);
        chk("rst_ack", {31'd0, h_ack}, 32'd0);
        chk("rst_gnt", {31'd0, h_gnt}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_imdata", im_data, 32'd0);
        chk("rst_hrdata", h_rdata, 32'd0);
        cyc();
        cyc();

        // Core fetch stream after reset release
        rst_n = 1'b1; h_req = 1'b0; h_we = 1'b0; im_addr = 32'd0;
        #3 chk("fetch0_valid", {31'd0, im_valid}, 32'd0);
        cyc(); im_addr = 32'd4;
        #3 chk("fetch1_valid", {31'd0, im_valid}, 32'd1);
        chk("fetch1_data", im_data, 32'hA000_0000);
        cyc(); im_addr = 32'd8;
        #3 chk("fetch2_data", im_data, 32'hA000_0004);
        chk("fetch2_ack", {31'd0, h_ack}, 32'd0);
        cyc();
        #3 chk("fetch3_data", im_data, 32'hA000_0008);

        // Host write then read back
        cyc(); h_req = 1'b1; h_we = 1'b1; h_addr = 32'h100; h_wdata = 32'hDEAD_BEEF;
        #3 chk("wr_gnt", {31'd0, h_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); h_req = 1'b0; h_we = 1'b0; im_addr = 32'hC;
        #3 chk("wr_ack", {31'd0, h_ack}, 32'd1);
        chk("wr_ack_valid", {31'd0, im_valid}, 32'd0);
        chk("core_mem_we", {31'd0, mem_we}, 32'd0);
        chk("core_mem_addr", mem_addr, 32'hC);
        cyc(); h_req = 1'b1; h_we = 1'b0; h_addr = 32'h100;
        #3 chk("rd_gnt", {31'd0, h_gnt}, 32'd1);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_prev_fetch", im_data, 32'hA000_000C);
        cyc(); h_req = 1'b0;
        #3 chk("rd_ack", {31'd0, h_ack}, 32'd1);
        chk("rd_data", h_rdata, 32'hDEAD_BEEF);
        chk("rd_ack_valid", {31'd0, im_valid}, 32'd0);

        // Held host request: burst / alternation pattern
        gv = 32'd0; av = 32'd0; vv = 32'd0;
        h_addr = 32'h10;
        for (int i = 0; i < HOLD_N; i++) begin
            cyc(); h_req = 1'b1;
            #3;
            gv = {gv[30:0], h_gnt};
            av = {av[30:0], h_ack};
            vv = {vv[30:0], im_valid};
        end
        chk("hold_gnt", gv, EXP_GNT);
        chk("hold_ack", av, EXP_ACK);
        chk("hold_valid", vv, EXP_VALID);
        chk("hold_exclusive", av & vv, 32'd0);
        cyc(); h_req = 1'b0;
        #3 chk("drop_gnt", {31'd0, h_gnt}, 32'd0);

        // Reset in the middle of a host write burst
        cyc(); h_req = 1'b1; h_we = 1'b1; h_addr = 32'h200; h_wdata = 32'h1234_5678;
        #3 chk("mid_gnt0", {31'd0, h_gnt}, 32'd1);
`ifdef URV_IMEM_ARB_BURST_EN
        cyc(); h_addr = 32'h204; h_wdata = 32'h9ABC_DEF0;
        #3 chk("mid_gnt1", {31'd0, h_gnt}, 32'd1);
`endif
        cyc(); rst_n = 1'b0;
        #1 chk("mid_rst_ack", {31'd0, h_ack}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_gnt", {31'd0, h_gnt}, 32'd0);
        chk("mid_rst_valid", {31'd0, im_valid}, 32'd0);
        cyc(); rst_n = 1'b1; h_req = 1'b0; h_we = 1'b0; im_addr = 32'h200;
        #3 chk("post_rst_valid0", {31'd0, im_valid}, 32'd0);
        chk("post_rst_ack0", {31'd0, h_ack}, 32'd0);
        cyc(); im_addr = 32'h204;
        #3 chk("post_rst_valid1", {31'd0, im_valid}, 32'd1);
        chk("post_rst_data200", im_data, 32'h1234_5678);
`ifdef URV_IMEM_ARB_BURST_EN
        cyc();
        #3 chk("post_rst_data204", im_data, 32'h9ABC_DEF0);
`endif
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
